// File: rtl/hash_table_arbiter.sv
// Two-port round-robin front end for probing_mem: accepts one command at a time, issues it
// with a single go pulse, waits a bounded time for a result code and returns a tagged response.
module hash_table_arbiter #(
  parameter int KEY_W   = 4,
  parameter int VAL_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [1:0]       a_cmd,
  input  logic [KEY_W-1:0] a_key,
  input  logic [VAL_W-1:0] a_val,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [1:0]       b_cmd,
  input  logic [KEY_W-1:0] b_key,
  input  logic [VAL_W-1:0] b_val,
  output logic [1:0]       mem_cmd,
  output logic [KEY_W-1:0] mem_key,
  output logic [VAL_W-1:0] mem_val,
  output logic             mem_go,
  input  logic [1:0]       mem_status,
  input  logic [VAL_W-1:0] mem_out,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [1:0]       rsp_status,
  output logic [VAL_W-1:0] rsp_data,
  output logic             rsp_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
  localparam logic [1:0] CMD_NOP = 2'b00;
  localparam logic [1:0] ST_NONE = 2'b00;
  localparam logic [1:0] ST_OK   = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t           state_q, state_d;
  logic             last_b_q, last_b_d;
  logic             id_q, id_d;
  logic [1:0]       cmd_q, cmd_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [VAL_W-1:0] val_q, val_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             rsp_id_q, rsp_id_d;
  logic [1:0]       rsp_status_q, rsp_status_d;
  logic [VAL_W-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_timeout_q, rsp_timeout_d;

  logic             grant_a, grant_b;
  logic [1:0]       sel_cmd;
  logic             mem_active;

  // On a tie the port that was not granted last wins; ready is gated by reset so every
  // output is low while rst is asserted.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state_q == S_IDLE && !rst) begin
      if (a_valid && b_valid) begin
        grant_a = last_b_q;
        grant_b = !last_b_q;
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;
  assign sel_cmd = grant_b ? b_cmd : a_cmd;

  // Saturating so the counter can never wrap past TIMEOUT.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d       = state_q;
    last_b_d      = last_b_q;
    id_d          = id_q;
    cmd_d         = cmd_q;
    key_d         = key_q;
    val_d         = val_q;
    cnt_d         = cnt_q;
    rsp_id_d      = rsp_id_q;
    rsp_status_d  = rsp_status_q;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      S_IDLE: begin
        if (grant_a || grant_b) begin
          cmd_d    = sel_cmd;
          key_d    = grant_b ? b_key : a_key;
          val_d    = grant_b ? b_val : a_val;
          id_d     = grant_b;
          last_b_d = grant_b;
          if (sel_cmd == CMD_NOP) begin
            state_d       = S_RESP;
            rsp_id_d      = grant_b;
            rsp_status_d  = ST_OK;
            rsp_data_d    = '0;
            rsp_timeout_d = 1'b0;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        cnt_d = cnt_inc;
        // The memory only sees go at the end of ISSUE, so any code seen here is fresh.
        if (mem_status != ST_NONE) begin
          state_d       = S_RESP;
          rsp_id_d      = id_q;
          rsp_status_d  = mem_status;
          rsp_data_d    = mem_out;
          rsp_timeout_d = 1'b0;
        end else if (cnt_inc == CNT_MAX) begin
          state_d       = S_RESP;
          rsp_id_d      = id_q;
          rsp_status_d  = ST_NONE;
          rsp_data_d    = '0;
          rsp_timeout_d = 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      last_b_q      <= 1'b1;
      id_q          <= 1'b0;
      cmd_q         <= 2'b00;
      key_q         <= '0;
      val_q         <= '0;
      cnt_q         <= '0;
      rsp_id_q      <= 1'b0;
      rsp_status_q  <= 2'b00;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_b_q      <= last_b_d;
      id_q          <= id_d;
      cmd_q         <= cmd_d;
      key_q         <= key_d;
      val_q         <= val_d;
      cnt_q         <= cnt_d;
      rsp_id_q      <= rsp_id_d;
      rsp_status_q  <= rsp_status_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // Memory-side payload is only presented while an operation is outstanding.
  assign mem_active = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign mem_go     = (state_q == S_ISSUE);
  assign mem_cmd    = mem_active ? cmd_q : 2'b00;
  assign mem_key    = mem_active ? key_q : '0;
  assign mem_val    = mem_active ? val_q : '0;

  assign rsp_valid   = (state_q == S_RESP);
  assign rsp_id      = rsp_id_q;
  assign rsp_status  = rsp_status_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_hash_table_arbiter.sv
// Bench for hash_table_arbiter: directed scenarios followed by random traffic, checked against a
// transaction-level model (arbitration order, completion cycle, response contents).
module tb_hash_table_arbiter;

  localparam int KEY_W   = 4;
  localparam int VAL_W   = 4;
  localparam int TIMEOUT = 15;

  logic             clk = 1'b0;
  logic             rst;
  logic             a_valid, a_ready, b_valid, b_ready;
  logic [1:0]       a_cmd, b_cmd;
  logic [KEY_W-1:0] a_key, b_key;
  logic [VAL_W-1:0] a_val, b_val;
  logic [1:0]       mem_cmd;
  logic [KEY_W-1:0] mem_key;
  logic [VAL_W-1:0] mem_val;
  logic             mem_go;
  logic [1:0]       mem_status;
  logic [VAL_W-1:0] mem_out;
  logic             rsp_valid, rsp_id, rsp_timeout;
  logic [1:0]       rsp_status;
  logic [VAL_W-1:0] rsp_data;

  hash_table_arbiter #(.KEY_W(KEY_W), .VAL_W(VAL_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_cmd(a_cmd), .a_key(a_key), .a_val(a_val),
    .b_valid(b_valid), .b_ready(b_ready), .b_cmd(b_cmd), .b_key(b_key), .b_val(b_val),
    .mem_cmd(mem_cmd), .mem_key(mem_key), .mem_val(mem_val), .mem_go(mem_go),
    .mem_status(mem_status), .mem_out(mem_out),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_status(rsp_status),
    .rsp_data(rsp_data), .rsp_timeout(rsp_timeout)
  );

  always #5 clk = ~clk;

  // A request plus how the memory will answer it: result appears dly cycles into WAIT.
  typedef struct {
    logic [1:0]       cmd;
    logic [KEY_W-1:0] key;
    logic [VAL_W-1:0] val;
    int               dly;
    logic [1:0]       st;
    logic [VAL_W-1:0] out;
  } req_t;

  typedef struct {
    int id;
    int st;
    int data;
    int to;
    int c;
  } rsp_t;

  req_t qa[$];
  req_t qb[$];
  rsp_t rlog[$];

  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   free_at = 0;
  int   go_cyc = 0;
  int   rsp_cyc = 0;
  int   acc_cyc = 0;
  int   n_go = 0;
  int   gen_left = 0;
  bit   rand_mode = 0;
  bit   last_b = 1;
  bit   busy = 0;
  req_t cur;
  bit   cur_id;
  logic [1:0]       exp_st;
  logic [VAL_W-1:0] exp_data;
  logic             exp_to;
  logic             hold_id;
  logic [1:0]       hold_st;
  logic [VAL_W-1:0] hold_data;
  logic             hold_to;
  bit   m_active = 0;
  int   m_rem = 0;
  req_t m_req;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask

  function automatic req_t mk(input logic [1:0] cmd, input int key, input int val,
                              input int dly, input logic [1:0] st, input int out);
    req_t r;
    r.cmd = cmd;
    r.key = KEY_W'(key);
    r.val = VAL_W'(val);
    r.dly = dly;
    r.st  = st;
    r.out = VAL_W'(out);
    return r;
  endfunction

  function automatic req_t rand_req();
    int d;
    d = ($urandom_range(0, 9) == 0) ? 1000 : int'($urandom_range(0, TIMEOUT));
    return mk(2'($urandom_range(0, 3)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
              d, 2'($urandom_range(1, 3)), int'($urandom_range(0, 15)));
  endfunction

  function automatic rsp_t get_rsp(input int idx);
    rsp_t r;
    r = '{-1, -1, -1, -1, -1};
    if (idx < rlog.size()) r = rlog[idx];
    return r;
  endfunction

  task automatic step();
    logic exp_go, exp_rv, exp_a, exp_b, pa, pb;
    @(negedge clk);
    cyc++;
    exp_go = busy && (cur.cmd != 2'b00) && (cyc == go_cyc);
    chk("mem_go", 32'(mem_go), 32'(exp_go));
    if (busy && cur.cmd != 2'b00 && cyc >= go_cyc && cyc < rsp_cyc)
      chk("mem_payload", 32'({mem_cmd, mem_key, mem_val}), 32'({cur.cmd, cur.key, cur.val}));
    if (cyc >= free_at)
      chk("mem_idle_zero", 32'({mem_cmd, mem_key, mem_val}), 32'(0));
    exp_rv = busy && (cyc == rsp_cyc);
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    if (exp_rv) begin
      hold_id   = cur_id;
      hold_st   = exp_st;
      hold_data = exp_data;
      hold_to   = exp_to;
      busy      = 0;
    end
    chk("rsp_fields", 32'({rsp_id, rsp_status, rsp_data, rsp_timeout}),
        32'({hold_id, hold_st, hold_data, hold_to}));
    if (rsp_valid === 1'b1)
      rlog.push_back('{int'(rsp_id), int'(rsp_status), int'(rsp_data), int'(rsp_timeout), cyc});

    // memory responder: status stays stale through ISSUE, then counts down in WAIT
    if (mem_go === 1'b1) begin
      n_go++;
      m_active = 1;
      m_rem    = m_req.dly;
    end else if (m_active) begin
      if (m_rem == 0) begin
        mem_status = m_req.st;
        mem_out    = m_req.out;
        m_active   = 0;
      end else begin
        m_rem--;
        mem_status = 2'b00;
      end
    end

    if (rand_mode) begin
      if (qa.size() == 0 && gen_left > 0 && $urandom_range(0, 2) == 0) begin
        qa.push_back(rand_req());
        gen_left--;
      end
      if (qb.size() == 0 && gen_left > 0 && $urandom_range(0, 2) == 0) begin
        qb.push_back(rand_req());
        gen_left--;
      end
    end
    pa = (qa.size() > 0);
    pb = (qb.size() > 0);
    a_valid = pa;
    b_valid = pb;
    if (pa) begin
      a_cmd = qa[0].cmd; a_key = qa[0].key; a_val = qa[0].val;
    end else begin
      a_cmd = 2'($urandom); a_key = KEY_W'($urandom); a_val = VAL_W'($urandom);
    end
    if (pb) begin
      b_cmd = qb[0].cmd; b_key = qb[0].key; b_val = qb[0].val;
    end else begin
      b_cmd = 2'($urandom); b_key = KEY_W'($urandom); b_val = VAL_W'($urandom);
    end
    #1;
    exp_a = (cyc >= free_at) && pa && (!pb || last_b);
    exp_b = (cyc >= free_at) && pb && !exp_a;
    chk("a_ready", 32'(a_ready), 32'(exp_a));
    chk("b_ready", 32'(b_ready), 32'(exp_b));
    if (exp_a || exp_b) begin
      cur     = exp_b ? qb.pop_front() : qa.pop_front();
      cur_id  = exp_b;
      last_b  = exp_b;
      acc_cyc = cyc;
      m_req   = cur;
      busy    = 1;
      go_cyc  = cyc + 1;
      if (cur.cmd == 2'b00) begin
        rsp_cyc = cyc + 1; exp_st = 2'b01; exp_data = '0; exp_to = 1'b0;
      end else if (cur.dly + 1 <= TIMEOUT) begin
        rsp_cyc = cyc + 3 + cur.dly; exp_st = cur.st; exp_data = cur.out; exp_to = 1'b0;
      end else begin
        rsp_cyc = cyc + 2 + TIMEOUT; exp_st = 2'b00; exp_data = '0; exp_to = 1'b1;
      end
      free_at = rsp_cyc + 1;
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((qa.size() > 0 || qb.size() > 0 || busy || gen_left > 0) && n < budget) begin
      step();
      n++;
    end
    chk("drain", 32'(qa.size() + qb.size() + int'(busy) + gen_left), 32'(0));
  endtask

  initial begin
    int   base, start, go0, n;
    rsp_t r;
    rst = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0;
    a_cmd = 2'b00; a_key = '0; a_val = '0;
    b_cmd = 2'b00; b_key = '0; b_val = '0;
    mem_status = 2'b00; mem_out = '0;
    cur = mk(2'b00, 0, 0, 0, 2'b01, 0);
    m_req = cur;
    cur_id = 0;
    hold_id = 1'b0; hold_st = 2'b00; hold_data = '0; hold_to = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 32'({mem_go, mem_cmd, mem_key, mem_val, rsp_valid, rsp_id, rsp_status,
                              rsp_data, rsp_timeout, a_ready, b_ready}), 32'(0));
    rst = 1'b0;

    // both ports contending: A, B, A, B
    base = rlog.size();
    qa.push_back(mk(2'b01, 1, 1, 0, 2'b01, 0));
    qb.push_back(mk(2'b01, 2, 2, 0, 2'b01, 0));
    qa.push_back(mk(2'b01, 3, 3, 1, 2'b01, 0));
    qb.push_back(mk(2'b01, 4, 4, 0, 2'b01, 0));
    drain(200);
    chk("rr_count", 32'(rlog.size() - base), 32'(4));
    for (int i = 0; i < 4; i++) begin
      r = get_rsp(base + i);
      chk("rr_order", 32'(r.id), 32'(i % 2));
    end

    // INSERT with two empty WAIT cycles
    base = rlog.size(); start = cyc + 1; go0 = n_go;
    qa.push_back(mk(2'b01, 5, 9, 2, 2'b01, 0));
    drain(100);
    r = get_rsp(base);
    chk("insert_latency", 32'(r.c - start), 32'(5));
    chk("insert_status", 32'(r.st), 32'(1));
    chk("insert_id", 32'(r.id), 32'(0));
    chk("insert_go_pulses", 32'(n_go - go0), 32'(1));

    // LOOKUP miss then hit from port B
    base = rlog.size();
    qb.push_back(mk(2'b10, 3, 0, 1, 2'b10, 0));
    qb.push_back(mk(2'b10, 3, 0, 3, 2'b01, 7));
    drain(100);
    r = get_rsp(base);
    chk("miss_id", 32'(r.id), 32'(1));
    chk("miss_status", 32'(r.st), 32'(2));
    chk("miss_data", 32'(r.data), 32'(0));
    r = get_rsp(base + 1);
    chk("hit_status", 32'(r.st), 32'(1));
    chk("hit_data", 32'(r.data), 32'(7));

    // stuck memory -> timeout; then a result arriving in the very last WAIT cycle
    base = rlog.size(); start = cyc + 1;
    qa.push_back(mk(2'b01, 4, 4, 1000, 2'b01, 5));
    drain(100);
    r = get_rsp(base);
    chk("timeout_latency", 32'(r.c - start), 32'(2 + TIMEOUT));
    chk("timeout_flag", 32'(r.to), 32'(1));
    chk("timeout_status", 32'(r.st), 32'(0));
    chk("timeout_data", 32'(r.data), 32'(0));
    base = rlog.size(); start = cyc + 1;
    qa.push_back(mk(2'b10, 4, 0, TIMEOUT - 1, 2'b01, 6));
    drain(100);
    r = get_rsp(base);
    chk("late_ok_latency", 32'(r.c - start), 32'(2 + TIMEOUT));
    chk("late_ok_flag", 32'(r.to), 32'(0));
    chk("late_ok_data", 32'(r.data), 32'(6));

    // NOP bypasses the memory; INSERT into a full table reports FULL
    base = rlog.size(); start = cyc + 1; go0 = n_go;
    qa.push_back(mk(2'b00, 1, 1, 0, 2'b11, 3));
    drain(50);
    r = get_rsp(base);
    chk("nop_latency", 32'(r.c - start), 32'(1));
    chk("nop_status", 32'(r.st), 32'(1));
    chk("nop_go_pulses", 32'(n_go - go0), 32'(0));
    base = rlog.size();
    qa.push_back(mk(2'b01, 7, 7, 4, 2'b11, 0));
    drain(50);
    r = get_rsp(base);
    chk("full_status", 32'(r.st), 32'(3));

    // reset asserted in the middle of WAIT
    qa.push_back(mk(2'b01, 6, 6, 1000, 2'b01, 0));
    n = 0;
    while ((!busy || cyc < acc_cyc + 4) && n < 50) begin
      step();
      n++;
    end
    base = rlog.size();
    #1 rst = 1'b1;
    #1;
    chk("async_reset_outputs", 32'({mem_go, mem_cmd, mem_key, mem_val, rsp_valid, rsp_id,
                                    rsp_status, rsp_data, rsp_timeout}), 32'(0));
    busy = 0; m_active = 0; last_b = 1;
    qa.delete(); qb.delete();
    a_valid = 1'b0; b_valid = 1'b0;
    mem_status = 2'b00; mem_out = '0;
    hold_id = 1'b0; hold_st = 2'b00; hold_data = '0; hold_to = 1'b0;
    @(negedge clk);
    chk("reset_no_rsp", 32'(rsp_valid), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    cyc = 0; free_at = 0;
    chk("reset_dropped_op", 32'(rlog.size() - base), 32'(0));
    qa.push_back(mk(2'b10, 6, 0, 2, 2'b01, 6));
    drain(50);
    r = get_rsp(base);
    chk("post_reset_status", 32'(r.st), 32'(1));
    chk("post_reset_data", 32'(r.data), 32'(6));

    // random traffic on both ports
    rand_mode = 1;
    gen_left = 250;
    drain(20000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, observed %0d checks expected completion", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
